gray_sched: RTL
===============

GRAY_SCHED -- requirements
Module: gray_sched

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Req  input  2  per-requester level request for a counting burst, bit i = requester i.
REQ-005 Len0  input  4  burst length for requester 0, 0..15 steps, sampled at grant.
REQ-006 Len1  input  4  burst length for requester 1, 0..15 steps, sampled at grant.
REQ-007 GrayIn  input  3  current value of the shared 3-bit Gray counter.
REQ-008 OvfIn  input  1  sticky overflow flag of the shared Gray counter.
REQ-009 CntClr  output  1  clear strobe to the shared counter's reset input, one cycle per burst.
REQ-010 CntEn  output  1  count enable to the shared counter.
REQ-011 Grant  output  2  one-hot owner of the counter; 2'b00 when idle.
REQ-012 Done  output  2  one-cycle completion pulse, bit i = requester i.
REQ-013 Value  output  3  final Gray value of the burst; valid only while Done != 0, 3'b000 otherwise.
REQ-014 Wrap  output  1  counter overflowed during the burst; valid only while Done != 0, 0 otherwise.
REQ-015 Busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ARB, RUN and DONE.
REQ-017 IDLE: if Req != 0, the block SHALL select a winner, record it and go to ARB; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with one requester active, that requester wins; with both active, the requester not equal to LastGnt wins.
REQ-019 LastGnt SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 ARB (one cycle): Grant = winner, CntClr = 1, CntEn = 0; Rem SHALL load the winner's Len and LastGnt SHALL update to the winner.
REQ-021 From ARB, the FSM SHALL go to RUN if the loaded Len != 0, or directly to DONE if Len == 0.
REQ-022 RUN: CntEn = 1 and Grant held for exactly Len consecutive cycles; Rem decrements each cycle, and the FSM goes to DONE on the cycle Rem == 1.
REQ-023 DONE (one cycle): Grant held, CntEn = 0, Done[winner] = 1, Value = GrayIn, Wrap = OvfIn; the next state SHALL be IDLE.
REQ-024 Latency: the first Done pulse SHALL appear Len+2 cycles after the IDLE cycle in which Req is sampled high.
REQ-025 Between consecutive bursts there SHALL be exactly one IDLE cycle.
REQ-026 Req changes after grant SHALL be ignored: a burst always completes and Done always pulses.
REQ-027 Len0/Len1 changes after ARB SHALL NOT affect the burst in progress.
REQ-028 A Req bit still high in the IDLE cycle after its Done SHALL count as a new request.
REQ-029 Because CntClr precedes each burst, Value SHALL equal the Gray code of (Len mod 8), and Wrap SHALL be 1 exactly when Len >= 8.
REQ-030 Grant SHALL be one-hot or zero at all times, and CntEn SHALL never be high outside RUN.
REQ-031 Rem SHALL be 4 bits wide, with no underflow: RUN is never entered with Rem == 0.

Reset
REQ-032 On Reset: state = IDLE, LastGnt = 1, Rem = 0, Grant = 0, Done = 0, CntEn = 0, CntClr = 0, Value = 0, Wrap = 0, Busy = 0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no Done pulse.
REQ-034 The system Reset also resets the shared counter, so no CntClr is issued for an aborted burst.
REQ-035 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-036 Req=01, Len0=5 -> ARB with CntClr=1, then CntEn high for 5 cycles, then Done=01, Value=3'b111, Wrap=0, with Done 7 cycles after the request is sampled.
REQ-037 Req=10, Len1=10 -> CntEn high for 10 cycles, then Done=10, Value=3'b011, Wrap=1.
REQ-038 Req=11 from reset with Len0=Len1=2, Req held -> Grant=01 first, Done=01, one IDLE cycle, then Grant=10, Done=10, then Grant=01 again (alternating).
REQ-039 Req=01, Len0=0 -> ARB then DONE immediately, CntEn never high, Done=01, Value=3'b000, Wrap=0.
REQ-040 Req=01, Len0=8, Reset asserted on the 3rd RUN cycle -> next cycle all outputs at reset values, no Done pulse; a later Req=11 grants requester 0.
REQ-041 Req dropped to 0 and Len0 changed during RUN -> burst completes with the original length and Done still pulses.

Source files
------------

// File: rtl/gray_sched.sv
// Round-robin scheduler that lends a shared 3-bit Gray counter to one of two
// requesters for a burst of Len count steps and reports the final code.
module gray_sched (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic [3:0] Len0,
  input  logic [3:0] Len1,
  input  logic [2:0] GrayIn,
  input  logic       OvfIn,
  output logic       CntClr,
  output logic       CntEn,
  output logic [1:0] Grant,
  output logic [1:0] Done,
  output logic [2:0] Value,
  output logic       Wrap,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_r;
  logic       last_r;
  logic       win_r;
  logic [3:0] rem_r;
  logic [1:0] grant_r;
  logic [1:0] done_r;
  logic       cnt_clr_r;
  logic       cnt_en_r;
  logic       win_s;
  logic [3:0] len_sel_s;

  // With both requesting, the one that did not own the counter last time wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    case (req)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~last;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] to_onehot(input logic idx);
    if (idx) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

  // Winner selection and burst length of the recorded winner.
  always_comb begin
    win_s = pick_winner(Req, last_r);
    if (win_r) begin
      len_sel_s = Len1;
    end else begin
      len_sel_s = Len0;
    end
  end

  // Scheduler FSM with registered strobes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      last_r    <= 1'b1;
      win_r     <= 1'b0;
      rem_r     <= 4'd0;
      grant_r   <= 2'b00;
      done_r    <= 2'b00;
      cnt_clr_r <= 1'b0;
      cnt_en_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Req != 2'b00) begin
            win_r     <= win_s;
            grant_r   <= to_onehot(win_s);
            cnt_clr_r <= 1'b1;
            state_r   <= ARB;
          end else begin
            grant_r   <= 2'b00;
            cnt_clr_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        ARB: begin
          cnt_clr_r <= 1'b0;
          rem_r     <= len_sel_s;
          last_r    <= win_r;
          if (len_sel_s != 4'd0) begin
            cnt_en_r <= 1'b1;
            state_r  <= RUN;
          end else begin
            done_r  <= to_onehot(win_r);
            state_r <= DONE;
          end
        end
        RUN: begin
          rem_r <= rem_r - 4'd1;
          if (rem_r == 4'd1) begin
            cnt_en_r <= 1'b0;
            done_r   <= to_onehot(win_r);
            state_r  <= DONE;
          end else begin
            state_r  <= RUN;
          end
        end
        DONE: begin
          grant_r <= 2'b00;
          done_r  <= 2'b00;
          state_r <= IDLE;
        end
        default: begin
          grant_r   <= 2'b00;
          done_r    <= 2'b00;
          cnt_clr_r <= 1'b0;
          cnt_en_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // The counter takes its last step on the edge that enters DONE, so the
  // final code is only visible during DONE itself; pass it through gated.
  always_comb begin
    if (state_r == DONE) begin
      Value = GrayIn;
      Wrap  = OvfIn;
    end else begin
      Value = 3'b000;
      Wrap  = 1'b0;
    end
  end

  assign CntClr = cnt_clr_r;
  assign CntEn  = cnt_en_r;
  assign Grant  = grant_r;
  assign Done   = done_r;
  assign Busy   = (state_r != IDLE);

endmodule
